data_mem_lsu: RTL and testbench
===============================

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter DM_ADDRESS, default 9, meaning byte-address width; memory size is 2**DM_ADDRESS bytes.
REQ-002 Parameter DATA_W, default 32, meaning word width; legal values are 32 and 64.
REQ-003 Parameter INIT_ZERO, default 1, meaning the array is cleared by reset when 1 and left untouched by reset when 0.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RISC-V funct3 of the load/store.
REQ-010 req_addr  input  DM_ADDRESS  byte address.
REQ-011 req_wdata  input  DATA_W  store data, LSB-aligned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_rdata  output  DATA_W  load result, extended to DATA_W; 0 for stores and faults.
REQ-015 rsp_err  output  1  misaligned access or unsupported funct3.

Function
REQ-016 The storage array shall be byte-lane organised: 2**DM_ADDRESS/(DATA_W/8) words of DATA_W bits, word index = req_addr[DM_ADDRESS-1:log2(DATA_W/8)], with a byte write-enable per lane.
REQ-017 The FSM shall have three states. IDLE: req_ready=1. ACCESS: req_ready=0. RESP: rsp_valid=1, req_ready=0.
REQ-018 A handshake (req_valid & req_ready) in IDLE shall register all request fields and move to ACCESS.
REQ-019 The array read or write shall occur on the clock edge that leaves ACCESS; the FSM then enters RESP, so rsp_valid rises exactly 2 cycles after acceptance.
REQ-020 The FSM shall hold RESP with rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE; there shall be no request/response overlap, and at most one request is outstanding.
REQ-021 Loads shall be decoded as follows: 000 LB sign-extend, 001 LH sign-extend, 010 LW sign-extend to DATA_W, 100 LBU zero-extend, 101 LHU zero-extend, 110 LWU zero-extend, 011 LD load full word.
REQ-022 LWU and LD shall be legal only when DATA_W=64.
REQ-023 Stores shall be decoded as 000 SB, 001 SH, 010 SW, and 011 SD (DATA_W=64 only); the write data is replicated to the addressed lane(s), only the addressed byte-enables are set, and the other bytes are unchanged.
REQ-024 Lane selection shall use offset = req_addr[log2(DATA_W/8)-1:0].
REQ-025 Access size shall be 1, 2, 4 or 8 bytes, and any offset not a multiple of the size shall be misaligned.
REQ-026 A misaligned or unsupported request shall be accepted, shall bypass the array (no write, no read), shall go IDLE->RESP in 1 cycle, and shall set rsp_err=1 with rsp_rdata=0.
REQ-027 A store response shall carry rsp_rdata=0 and rsp_err=0.
REQ-028 req_valid asserted while not IDLE shall be ignored (no acceptance) and shall have no side effects.
REQ-029 The highest address 2**DM_ADDRESS-1 shall be valid for byte access, and addresses shall not wrap.

Reset
REQ-030 rst_n=0 shall force IDLE, with req_ready=1 after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, and registered request fields cleared.
REQ-031 Reset mid-ACCESS shall abort the operation; if reset arrives before the write edge, no array write occurs.
REQ-032 Reset in RESP shall drop the pending response.
REQ-033 If INIT_ZERO=1, every array byte shall read 0 after reset.
REQ-034 Release of rst_n shall be synchronised by the parent; the block shall not rely on release within the same cycle.

Verification
REQ-035 Sequence check (DATA_W=32): SW 0x8000_00F1 at addr 0x10, then LB 0x10 -> 0xFFFF_FFF1; LBU 0x10 -> 0x0000_00F1; LH 0x12 -> 0xFFFF_8000; LW 0x10 -> 0x8000_00F1; each rsp_valid 2 cycles after accept.
REQ-036 Byte-merge check: SW 0x1122_3344 at 0x20, SB 0xAA at 0x21, SH 0xBEEF at 0x22, then LW 0x20 -> 0xBEEF_AA44.
REQ-037 Misaligned check: LW at 0x13 -> rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept; SH at 0x21 -> rsp_err=1, and a following LW 0x20 is unchanged.
REQ-038 Backpressure check: hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable; req_ready=0; a second req_valid is not accepted until 1 cycle after rsp_ready=1.
REQ-039 DATA_W=64 check: SD 0x8877_6655_4433_2211 at 0x08, then LWU 0x0C -> 0x0000_0000_8877_6655, LW 0x0C -> 0xFFFF_FFFF_8877_6655, LD 0x08 -> full word; LD 0x0C -> rsp_err=1.
REQ-040 Reset check: assert rst_n=0 during ACCESS of SW 0xDEAD_BEEF at 0x30 -> outputs reach their reset values immediately; with INIT_ZERO=1, LW 0x30 -> 0.

Source files
------------

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between a load/store pipeline stage and the data memory.
// The master issues one request at a time and consumes the response.
interface data_mem_lsu_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [2:0]            req_funct3;
   logic [DM_ADDRESS-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-lane data memory with a RISC-V style load/store front end.
// One request outstanding; faulting requests skip the array and answer with rsp_err.
module data_mem_lsu #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int INIT_ZERO  = 1
) (
   input logic              clk,
   input logic              rst_n,
   data_mem_lsu_if.slave    bus
);
   localparam int NB    = DATA_W / 8;
   localparam int OFFW  = $clog2(NB);
   localparam int WAW   = DM_ADDRESS - OFFW;
   localparam int DEPTH = 1 << WAW;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                r_state;
   logic                  r_req_ready, r_rsp_valid, r_rsp_err;
   logic [DATA_W-1:0]     r_rsp_rdata;
   logic                  r_we, r_uns;
   logic [3:0]            r_size;
   logic [DM_ADDRESS-1:0] r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_mem [DEPTH];

   logic [3:0]            w_size, w_off4;
   logic                  w_legal, w_bad;
   logic [OFFW-1:0]       w_off;
   logic [WAW-1:0]        w_widx;
   logic [NB-1:0]         w_be;
   logic [DATA_W-1:0]     w_wrep, w_word, w_sh, w_mask, w_ld;
   logic                  w_sign, w_wr;

   // Request decode straight off the bus, used only on the accept edge
   always_comb begin
      w_size  = 4'd1;
      w_legal = 1'b1;
      case (bus.req_funct3)
         3'b000, 3'b100: w_size = 4'd1;
         3'b001, 3'b101: w_size = 4'd2;
         3'b010:         w_size = 4'd4;
         3'b110: begin w_size = 4'd4; w_legal = (DATA_W == 64) && !bus.req_we; end
         3'b011: begin w_size = 4'd8; w_legal = (DATA_W == 64); end
         default:        w_legal = 1'b0;
      endcase
      if (bus.req_we && bus.req_funct3[2]) w_legal = 1'b0;
      w_off4 = 4'(bus.req_addr[OFFW-1:0]);
      w_bad  = !w_legal || ((w_off4 & (w_size - 4'd1)) != 4'd0);
   end

   assign w_off  = r_addr[OFFW-1:0];
   assign w_widx = r_addr[DM_ADDRESS-1:OFFW];
   assign w_wr   = (r_state == S_ACCESS) && r_we;

   // Lane k of an access lands on byte (k mod size) of the store data
   always_comb begin
      w_be   = '0;
      w_wrep = '0;
      for (int b = 0; b < NB; b++) begin
         w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + int'(r_size));
         w_wrep[8*b +: 8] = r_wdata[8*(b & (int'(r_size) - 1)) +: 8];
      end
   end

   assign w_word = r_mem[w_widx];
   assign w_sh   = w_word >> {w_off, 3'b000};

   always_comb begin
      case (r_size)
         4'd1:    w_sign = w_sh[7];
         4'd2:    w_sign = w_sh[15];
         4'd4:    w_sign = w_sh[31];
         default: w_sign = w_sh[DATA_W-1];
      endcase
      w_mask = '0;
      for (int i = 0; i < DATA_W; i++) w_mask[i] = (i < 8 * int'(r_size));
      w_ld = (w_sh & w_mask) | ((w_sign && !r_uns) ? ~w_mask : '0);
   end

   generate
      if (INIT_ZERO != 0) begin : g_mem_clr
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int w = 0; w < DEPTH; w++) r_mem[w] <= '0;
            end else if (w_wr) begin
               for (int b = 0; b < NB; b++)
                  if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wrep[8*b +: 8];
            end
         end
      end else begin : g_mem_keep
         always_ff @(posedge clk) begin
            if (w_wr) begin
               for (int b = 0; b < NB; b++)
                  if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wrep[8*b +: 8];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_we        <= 1'b0;
         r_uns       <= 1'b0;
         r_size      <= 4'd0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.req_valid) begin
               r_we        <= bus.req_we;
               r_uns       <= bus.req_funct3[2];
               r_size      <= w_size;
               r_addr      <= bus.req_addr;
               r_wdata     <= bus.req_wdata;
               r_req_ready <= 1'b0;
               if (w_bad) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               r_rsp_rdata <= r_we ? '0 : w_ld;
               r_rsp_err   <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: if (bus.rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: a 32-bit and a 64-bit instance share clock and reset.
// Expected responses are queued at issue and checked when rsp_valid appears.
module tb_data_mem_lsu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) b32 ();
   data_mem_lsu_if #(.DM_ADDRESS(9), .DATA_W(64)) b64 ();

   data_mem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .INIT_ZERO(1)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32.slave));
   data_mem_lsu #(.DM_ADDRESS(9), .DATA_W(64), .INIT_ZERO(1)) dut64 (
      .clk(clk), .rst_n(rst_n), .bus(b64.slave));

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic drv(input bit sel, input logic v, input logic we, input logic [2:0] f3,
                      input logic [8:0] a, input logic [63:0] wd);
      if (sel) begin
         b64.req_valid = v; b64.req_we = we; b64.req_funct3 = f3;
         b64.req_addr = a; b64.req_wdata = wd;
      end else begin
         b32.req_valid = v; b32.req_we = we; b32.req_funct3 = f3;
         b32.req_addr = a; b32.req_wdata = wd[31:0];
      end
   endtask

   task automatic set_rr(input bit sel, input logic v);
      if (sel) b64.rsp_ready = v; else b32.rsp_ready = v;
   endtask

   function automatic logic rv(input bit sel);
      return sel ? b64.rsp_valid : b32.rsp_valid;
   endfunction
   function automatic logic rr(input bit sel);
      return sel ? b64.req_ready : b32.req_ready;
   endfunction
   function automatic logic re(input bit sel);
      return sel ? b64.rsp_err : b32.rsp_err;
   endfunction
   function automatic logic [63:0] rd(input bit sel);
      return sel ? b64.rsp_rdata : {32'h0, b32.rsp_rdata};
   endfunction

   // Issue one request; lat counts clock edges from the accepting edge to rsp_valid
   task automatic xact(input string tag, input bit sel, input logic we, input logic [2:0] f3,
                       input logic [8:0] a, input logic [63:0] wd,
                       input logic [63:0] ed, input logic ee, input int el, input int hold = 0);
      exp_t o;
      int lat;
      sb_q.push_back('{ed, ee, el});
      @(negedge clk);
      chk({tag, ".rdy"}, 64'(rr(sel)), 64'd1);
      set_rr(sel, hold == 0);
      drv(sel, 1'b1, we, f3, a, wd);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
         if (lat == 1) drv(sel, 1'b0, we, f3, a, wd);
      end while (!rv(sel) && lat < 20);
      o = sb_q.pop_front();
      chk({tag, ".vld"}, 64'(rv(sel)), 64'd1);
      chk({tag, ".data"}, rd(sel), o.data);
      chk({tag, ".err"}, 64'(re(sel)), 64'(o.err));
      chk({tag, ".lat"}, 64'(lat), 64'(o.lat));
      if (hold > 0) begin
         drv(sel, 1'b1, 1'b1, 3'b010, 9'h040, 64'h5555_5555);
         repeat (hold) begin
            @(posedge clk);
            #1;
            chk({tag, ".hvld"}, 64'(rv(sel)), 64'd1);
            chk({tag, ".hdata"}, rd(sel), o.data);
            chk({tag, ".hrdy"}, 64'(rr(sel)), 64'd0);
         end
         set_rr(sel, 1'b1);
         @(posedge clk);
         #1;
         drv(sel, 1'b0, 1'b0, 3'b010, 9'h0, 64'h0);
         chk({tag, ".rvld"}, 64'(rv(sel)), 64'd0);
         chk({tag, ".rrdy"}, 64'(rr(sel)), 64'd1);
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      drv(1'b0, 1'b0, 1'b0, 3'b000, 9'h0, 64'h0);
      drv(1'b1, 1'b0, 1'b0, 3'b000, 9'h0, 64'h0);
      set_rr(1'b0, 1'b1);
      set_rr(1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.rdy32", 64'(rr(1'b0)), 64'd1);
      chk("rst.vld32", 64'(rv(1'b0)), 64'd0);
      chk("rst.err32", 64'(re(1'b0)), 64'd0);
      chk("rst.data32", rd(1'b0), 64'd0);
      chk("rst.rdy64", 64'(rr(1'b1)), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      xact("init_lw", 0, 0, 3'b010, 9'h010, 0, 64'h0, 0, 2);
      // sign/zero extension
      xact("sw10",  0, 1, 3'b010, 9'h010, 64'h8000_00F1, 64'h0, 0, 2);
      xact("lb10",  0, 0, 3'b000, 9'h010, 0, 64'hFFFF_FFF1, 0, 2);
      xact("lbu10", 0, 0, 3'b100, 9'h010, 0, 64'h0000_00F1, 0, 2);
      xact("lh12",  0, 0, 3'b001, 9'h012, 0, 64'hFFFF_8000, 0, 2);
      xact("lhu12", 0, 0, 3'b101, 9'h012, 0, 64'h0000_8000, 0, 2);
      xact("lw10",  0, 0, 3'b010, 9'h010, 0, 64'h8000_00F1, 0, 2);
      // byte merge
      xact("sw20",  0, 1, 3'b010, 9'h020, 64'h1122_3344, 64'h0, 0, 2);
      xact("sb21",  0, 1, 3'b000, 9'h021, 64'hAA, 64'h0, 0, 2);
      xact("sh22",  0, 1, 3'b001, 9'h022, 64'hBEEF, 64'h0, 0, 2);
      xact("lw20",  0, 0, 3'b010, 9'h020, 0, 64'hBEEF_AA44, 0, 2);
      // faults
      xact("lw13",  0, 0, 3'b010, 9'h013, 0, 64'h0, 1, 1);
      xact("sh21",  0, 1, 3'b001, 9'h021, 64'h7777, 64'h0, 1, 1);
      xact("lw20b", 0, 0, 3'b010, 9'h020, 0, 64'hBEEF_AA44, 0, 2);
      xact("lwu32", 0, 0, 3'b110, 9'h020, 0, 64'h0, 1, 1);
      xact("ld32",  0, 0, 3'b011, 9'h020, 0, 64'h0, 1, 1);
      xact("f111",  0, 0, 3'b111, 9'h020, 0, 64'h0, 1, 1);
      // top of memory
      xact("sb1ff", 0, 1, 3'b000, 9'h1FF, 64'h5A, 64'h0, 0, 2);
      xact("lbu1ff",0, 0, 3'b100, 9'h1FF, 0, 64'h5A, 0, 2);
      xact("lw1fc", 0, 0, 3'b010, 9'h1FC, 0, 64'h5A00_0000, 0, 2);
      // backpressure
      xact("bp",    0, 0, 3'b010, 9'h020, 0, 64'hBEEF_AA44, 0, 2, 5);
      xact("bp.nw", 0, 0, 3'b010, 9'h040, 0, 64'h0, 0, 2);
      // 64-bit instance
      xact("sd08",  1, 1, 3'b011, 9'h008, 64'h8877_6655_4433_2211, 64'h0, 0, 2);
      xact("lwu0c", 1, 0, 3'b110, 9'h00C, 0, 64'h0000_0000_8877_6655, 0, 2);
      xact("lw0c",  1, 0, 3'b010, 9'h00C, 0, 64'hFFFF_FFFF_8877_6655, 0, 2);
      xact("ld08",  1, 0, 3'b011, 9'h008, 0, 64'h8877_6655_4433_2211, 0, 2);
      xact("ld0c",  1, 0, 3'b011, 9'h00C, 0, 64'h0, 1, 1);
      xact("sw0c",  1, 1, 3'b010, 9'h00C, 64'h1234_5678, 64'h0, 0, 2);
      xact("ld08b", 1, 0, 3'b011, 9'h008, 0, 64'h1234_5678_4433_2211, 0, 2);
      xact("lh0e",  1, 0, 3'b001, 9'h00E, 0, 64'h0000_0000_0000_1234, 0, 2);

      // reset during ACCESS of a store
      @(negedge clk);
      drv(1'b0, 1'b1, 1'b1, 3'b010, 9'h030, 64'hDEAD_BEEF);
      @(posedge clk);
      #1;
      drv(1'b0, 1'b0, 1'b0, 3'b010, 9'h0, 64'h0);
      chk("arst.busy", 64'(rr(1'b0)), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.rdy", 64'(rr(1'b0)), 64'd1);
      chk("arst.vld", 64'(rv(1'b0)), 64'd0);
      chk("arst.err", 64'(re(1'b0)), 64'd0);
      chk("arst.data", rd(1'b0), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      xact("lw30",  0, 0, 3'b010, 9'h030, 0, 64'h0, 0, 2);
      xact("lw20z", 0, 0, 3'b010, 9'h020, 0, 64'h0, 0, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
